// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Brief    : IO address map, io_enable bit indices and rd_data field layout
//            shared by the input reader and its debouncers.
// Revision : 1.0 - initial release
// ============================================================================
package io_pkg;

    localparam int unsigned c_ADDR_LEDS     = 32;
    localparam int unsigned c_ADDR_SWITCHES = 33;
    localparam int unsigned c_ADDR_BUTTONS  = 34;
    localparam int unsigned c_ADDR_SEG7     = 35;

    localparam int unsigned c_EN_SW_BIT     = 1;
    localparam int unsigned c_EN_BTN_BIT    = 2;

    localparam int unsigned c_BTN_LEVEL_LSB = 0;
    localparam int unsigned c_BTN_EVENT_LSB = 8;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_SW   = 2'd1,
        RD_BTN  = 2'd2
    } rd_sel_e;

    // Switch read wins when both selects are high, so events are not consumed.
    function automatic rd_sel_e decode_rd_sel(input logic sw_en, input logic btn_en);
        if (sw_en) begin
            return RD_SW;
        end else if (btn_en) begin
            return RD_BTN;
        end
        return RD_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// ============================================================================
// Module   : io_debounce
// Brief    : One-bit two-flop synchronizer followed by a stable-count debouncer.
// Revision : 1.0 - initial release
// ============================================================================
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES);

    logic               r_meta;
    logic               r_sync;
    logic               r_stable;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_accept;

    assign w_accept = (r_sync != r_stable) && (r_cnt == c_CNT_MAX);
    // Flags the edge on which stable goes 0->1 so events line up with the level.
    assign o_rise   = w_accept && r_sync;
    assign o_stable = r_stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
            if (r_sync == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/io_input_reader.sv
`default_nettype none
// ============================================================================
// Module   : io_input_reader
// Brief    : Debounced switch/button reader with sticky press events and a
//            registered CPU read port.
// Revision : 1.0 - initial release
// ============================================================================
module io_input_reader
    import io_pkg::*;
#(
    parameter int SW_WIDTH        = 16,
    parameter int BTN_WIDTH       = 5,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           io_enable,
    input  logic [SW_WIDTH-1:0]  sw_raw,
    input  logic [BTN_WIDTH-1:0] btn_raw,
    output logic [31:0]          rd_data,
    output logic                 rd_valid,
    output logic                 btn_irq
);

    logic [SW_WIDTH-1:0]  w_sw_stable;
    logic [BTN_WIDTH-1:0] w_btn_stable;
    logic [BTN_WIDTH-1:0] w_btn_rise;
    logic [BTN_WIDTH-1:0] r_event;
    logic [BTN_WIDTH-1:0] w_event_clear;
    logic [BTN_WIDTH-1:0] w_event_next;
    logic [31:0]          w_rd_next;
    rd_sel_e              w_sel;
    logic                 w_unused;

    generate
        for (genvar i = 0; i < SW_WIDTH; i++) begin : g_sw
            io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk      (clk),
                .rst      (rst),
                .i_raw    (sw_raw[i]),
                .o_stable (w_sw_stable[i]),
                .o_rise   ()
            );
        end

        for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_btn
            io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk      (clk),
                .rst      (rst),
                .i_raw    (btn_raw[i]),
                .o_stable (w_btn_stable[i]),
                .o_rise   (w_btn_rise[i])
            );
        end
    endgenerate

    assign w_unused = &{1'b0, io_enable[0], io_enable[3]};
    assign w_sel    = decode_rd_sel(io_enable[c_EN_SW_BIT], io_enable[c_EN_BTN_BIT]);

    always_comb begin
        w_rd_next     = '0;
        w_event_clear = '0;
        case (w_sel)
            RD_SW: begin
                w_rd_next[SW_WIDTH-1:0] = w_sw_stable;
            end
            RD_BTN: begin
                w_rd_next[c_BTN_LEVEL_LSB +: BTN_WIDTH] = w_btn_stable;
                w_rd_next[c_BTN_EVENT_LSB +: BTN_WIDTH] = r_event;
                w_event_clear                           = r_event;
            end
            default: begin
            end
        endcase
    end

    // A press landing on the clearing edge survives: set overrides clear.
    assign w_event_next = (r_event & ~w_event_clear) | w_btn_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_event  <= '0;
            btn_irq  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            r_event  <= w_event_next;
            btn_irq  <= |w_event_next;
            rd_data  <= w_rd_next;
            rd_valid <= (w_sel != RD_NONE);
        end
    end

endmodule
`default_nettype wire

// File: doc/io_input_reader.md
IO_INPUT_READER -- requirements
Module: io_input_reader

Interface
REQ-001 Parameter SW_WIDTH, default 16, number of slide switches.
REQ-002 Parameter BTN_WIDTH, default 5, number of push buttons.
REQ-003 Parameter DEBOUNCE_CYCLES, default 100000, consecutive stable cycles required before an input change is accepted.
REQ-004 clk  input  1  single system clock; every register SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 io_enable  input  4  decoded IO select: bit1 = switch read (address 33), bit2 = button read (address 34), bits 0 and 3 ignored.
REQ-007 sw_raw  input  SW_WIDTH  asynchronous switch pins.
REQ-008 btn_raw  input  BTN_WIDTH  asynchronous button pins, 1 = pressed.
REQ-009 rd_data  output  32  registered read data to the CPU.
REQ-010 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-011 btn_irq  output  1  high while any button press event is pending.

Function
REQ-012 Each raw input bit SHALL pass through a two-flop synchronizer before any other use.
REQ-013 Each synchronized bit SHALL have its own debouncer with a stable value and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-014 Debounce rule: counter clears when synchronized value equals stable value; otherwise it increments; when it reaches DEBOUNCE_CYCLES, stable takes the synchronized value and the counter clears in the same cycle.
REQ-015 A pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave the stable value unchanged.
REQ-016 Latency: a clean raw edge SHALL appear in the stable value exactly DEBOUNCE_CYCLES+2 cycles after the first clk edge that samples it.
REQ-017 A 0->1 transition of a debounced button SHALL set that button's sticky event bit.
REQ-018 A switch read (io_enable[1]=1) SHALL load rd_data = {zero, sw_stable} on the next edge and assert rd_valid for that one cycle.
REQ-019 A button read (io_enable[2]=1, io_enable[1]=0) SHALL load rd_data with bits[BTN_WIDTH-1:0] = btn_stable and bits[8+BTN_WIDTH-1:8] = event bits; all other bits SHALL be 0.
REQ-020 A button read SHALL clear all event bits that it returned, in the same edge.
REQ-021 If a new press event and a clearing read occur in the same cycle, set SHALL win: the read returns the old value and the new event bit remains set.
REQ-022 If io_enable[1] and io_enable[2] are both high, the switch read SHALL take priority and events SHALL NOT be cleared.
REQ-023 Without a read in the previous cycle, rd_data SHALL be 0 and rd_valid SHALL be 0.
REQ-024 Back-to-back reads SHALL each produce a rd_valid pulse on consecutive cycles; there is no stall and no busy state.
REQ-025 btn_irq SHALL be the registered OR of all event bits.

Reset
REQ-026 While rst is high: synchronizer flops, stable values, counters, event bits, rd_data, rd_valid and btn_irq SHALL all be 0.
REQ-027 A reset during a debounce count SHALL discard the count; the stable value SHALL remain 0 until a full new debounce period elapses.
REQ-028 A switch held high through reset SHALL become visible DEBOUNCE_CYCLES+2 cycles after rst deasserts; buttons SHALL raise an event only on a debounced press after reset.

Structure
REQ-029 Package io_pkg SHALL hold the IO address constants (LEDS=32, SWITCHES=33, BUTTONS=34, SEG7=35), the io_enable bit indices and the rd_data button field offsets (level LSB 0, event LSB 8).
REQ-030 Sub-module io_debounce (one bit, parameter DEBOUNCE_CYCLES, synchronizer included) SHALL be instantiated once per switch and per button via generate.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 Reset, hold sw_raw=16'hA5C3 for 8 cycles, pulse io_enable[1] -> next cycle rd_data=32'h0000A5C3, rd_valid=1 for exactly one cycle.
REQ-032 btn_raw[0] high for 3 cycles, then read buttons -> rd_data=0, btn_irq stays 0.
REQ-033 btn_raw[2] held high for 10 cycles -> btn_irq=1; first read returns 32'h00000404; second read returns 32'h00000004 and btn_irq=0.
REQ-034 btn_raw[1] debounced edge lands in the same cycle as a read clearing event bit 2 -> read returns 32'h00000404 (with bit 1 level per timing); afterwards event bit 9 set, bit 10 clear.
REQ-035 Assert rst after 3 stable cycles of sw_raw[0]=1 -> after release, sw_stable[0]=0 until 6 further cycles have elapsed.
REQ-036 io_enable=4'b0110 with sw_stable=16'h0001 and event bit 0 pending -> rd_data=32'h00000001; event bit 0 still pending.
